multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main sequencer for the multicycle ARMv4 datapath: one shared ALU, one shared instruction/data memory port.
- Walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives every datapath select and write strobe.
- Holds the NZCV flag register and evaluates condition codes.
- Stalls on a memory-ready handshake and is driven from the instruction register fields.

Parameters:
- MEM_HANDSHAKE, 1, when 0, mem_ready is ignored and treated as constant 1 (zero-wait memory).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- Cond  input  4  Instr[31:28]
- Op  input  2  Instr[27:26]
- Funct  input  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S for DP, [0]=L for memory
- Rd  input  4  Instr[15:12]
- ALUFlags  input  4  NZCV from the ALU, same cycle
- mem_ready  input  1  memory access complete this cycle
- IRWrite  output  1  load instruction register
- PCWrite  output  1  load PC
- AdrSrc  output  1  0 = PC, 1 = ALUOut to memory address
- ALUSrcA  output  1  0 = register A, 1 = PC
- ALUSrcB  output  2  00 = register B, 01 = ExtImm, 10 = constant 4
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUControl  output  4  ALU command
- RegWrite  output  1  register file write
- MemWrite  output  1  memory write
- ImmSrc  output  2  equals Op
- RegSrc  output  2  [0] = (Op==10), [1] = (Op==01)
- Flags  output  4  registered NZCV
- state_o  output  4  current state encoding (debug)

Behaviour:
- States and encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
  - Encodings 10-15 are unused; if reached, they go to FETCH with all strobes 0.
- Reset:
  - reset high at an edge: state <= FETCH, Flags <= 0000.
  - While reset is high, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0 regardless of state, including reset asserted mid-MEMWRITE.
- Outputs: Moore decode of state; ImmSrc and RegSrc are combinational from Op in all states. Defaults are all strobes 0, ALUControl=0100 (ADD), other selects 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=PCWrite=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 precompute).
  - CondEx is evaluated from Cond and the registered Flags using standard ARM codes 0000 EQ ... 1110 AL; 1111 gives CondEx=0.
  - CondEx=0: go to FETCH. No further strobes for this instruction.
  - Otherwise by Op:
    - Op=01: go to MEMADR.
    - Op=00 with Funct[5]=0: go to EXECUTER.
    - Op=00 with Funct[5]=1: go to EXECUTEI.
    - Op=10: go to BRANCH.
    - Op=11: go to FETCH (treated as NOP).
- MEMADR:
  - ALUSrcB=01, ADD.
  - Funct[0]=1: go to MEMREAD. Funct[0]=0: go to MEMWRITE.
- MEMREAD: AdrSrc=1; holds until mem_ready, then goes to MEMWB.
- MEMWB:
  - ResultSrc=01, RegWrite=1.
  - PCWrite=1 if Rd=1111.
  - Next state is FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 every cycle until mem_ready; the cycle with mem_ready goes to FETCH.
- EXECUTER / EXECUTEI:
  - ALUSrcB=00 (EXECUTER) or 01 (EXECUTEI); ALUControl=Funct[4:1].
  - Next state is ALUWB.
  - If Funct[0]=1, Flags are updated at the end of this cycle from ALUFlags:
    - N and Z are always updated.
    - C and V are updated only for cmd 0100 ADD, 0010 SUB or 1010 CMP; otherwise they hold.
- ALUWB:
  - ResultSrc=00, RegWrite=1 unless cmd is 1010 (CMP) or 1000 (TST).
  - PCWrite=1 if RegWrite and Rd=1111.
  - Next state is FETCH.
- BRANCH:
  - ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1.
  - Next state is FETCH. The link bit Funct[4] is ignored.
- Latency with zero-wait memory:
  - DP: 4 cycles; LDR: 5; STR: 4; B: 3; condition-failed: 2.
  - Each mem_ready-low cycle adds 1.
- Flags change only in EXECUTER/EXECUTEI. A condition evaluated in DECODE always sees flags from a fully completed earlier instruction.

Test Plan:
- reset held 2 cycles mid-MEMWRITE -> MemWrite=0 during reset; state_o=0 and Flags=0000 the cycle after release.
- ADDS R1 (Op=00, Funct=001001, Cond=1110), ALUFlags=0110, mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in ALUWB; Flags=0110 after EXECUTER.
- CMP (Funct=010101) with ALUFlags=0100, then BEQ (Op=10, Cond=0000) -> no RegWrite for CMP; BEQ runs 0,1,9 with PCWrite=1 in BRANCH.
- BNE (Cond=0001) with Z=1 -> 0,1,0; PCWrite only in FETCH; no strobes in DECODE.
- LDR (Op=01, Funct[0]=1, Rd=1111), mem_ready low 2 cycles in MEMREAD -> MEMREAD lasts 3 cycles; MEMWB asserts RegWrite=1, ResultSrc=01, PCWrite=1.
- STR with MEM_HANDSHAKE=0 and mem_ready tied 0 -> 0,1,2,5,0 in 4 cycles; MemWrite high exactly 1 cycle.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle ARMv4 main sequencer: FETCH..WRITEBACK state walk, NZCV flags, condition check.
// Ports: clk/reset, instruction fields (Cond, Op, Funct, Rd), ALUFlags, mem_ready in;
//        datapath selects/strobes, Flags and state_o out.
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] ALUControl,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] Flags,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       rdy;
  logic       cond_ex;
  logic [3:0] cmd;
  logic       n, z, c, v;
  logic       wr_reg;

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign cmd = Funct[4:1];
  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = FETCH;
    flags_d    = flags_q;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 4'b0100;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    wr_reg     = 1'b0;
    unique case (state_q)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = rdy;
        PCWrite   = rdy;
        state_d   = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (!cond_ex) state_d = FETCH;
        else begin
          case (Op)
            2'b01:   state_d = MEMADR;
            2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
            2'b10:   state_d = BRANCH;
            default: state_d = FETCH;
          endcase
        end
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = rdy ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        PCWrite   = (Rd == 4'hF);
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = rdy ? FETCH : MEMWRITE;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB    = (state_q == EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = cmd;
        state_d    = ALUWB;
        if (Funct[0]) begin
          flags_d[3:2] = ALUFlags[3:2];
          // Only arithmetic commands produce meaningful carry/overflow.
          if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)
            flags_d[1:0] = ALUFlags[1:0];
        end
      end
      ALUWB: begin
        wr_reg   = (cmd != 4'b1010) && (cmd != 4'b1000);
        RegWrite = wr_reg;
        PCWrite  = wr_reg && (Rd == 4'hF);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    // Strobes must never fire while reset is held, whatever the state.
    if (reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  assign ImmSrc  = Op;
  assign RegSrc  = {(Op == 2'b01), (Op == 2'b10)};
  assign Flags   = flags_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (handshake and zero-wait instances).
// Drives instruction fields, checks states, strobes and flags against hand values.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       mem_ready;

  logic       IRWrite, PCWrite, AdrSrc, ALUSrcA, RegWrite, MemWrite;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [3:0] ALUControl, Flags, state_o;

  logic       IRWrite0, PCWrite0, AdrSrc0, ALUSrcA0, RegWrite0, MemWrite0;
  logic [1:0] ALUSrcB0, ResultSrc0, ImmSrc0, RegSrc0;
  logic [3:0] ALUControl0, Flags0, state0;

  int n_chk = 0;
  int n_pass = 0;
  int mw_cnt;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct),
    .Rd(Rd), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags), .state_o(state_o)
  );

  multicycle_control_fsm #(.MEM_HANDSHAKE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct),
    .Rd(Rd), .ALUFlags(ALUFlags), .mem_ready(1'b0),
    .IRWrite(IRWrite0), .PCWrite(PCWrite0), .AdrSrc(AdrSrc0),
    .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0), .ResultSrc(ResultSrc0),
    .ALUControl(ALUControl0), .RegWrite(RegWrite0), .MemWrite(MemWrite0),
    .ImmSrc(ImmSrc0), .RegSrc(RegSrc0), .Flags(Flags0), .state_o(state0)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, {IRWrite, PCWrite, RegWrite, MemWrite}, exp);
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1;
    Cond = 4'hE; Op = 2'b01; Funct = 6'b000000; Rd = 4'h0; ALUFlags = 4'h0;
    tick();
    reset = 1'b0;
    // STR walk into MEMWRITE, then reset in the middle of it
    #1 chk("str_fetch", state_o, 0);
    tick(); chk("str_dec", state_o, 1);
    tick(); chk("str_adr", {state_o, 2'b00, ALUSrcB}, {4'd2, 2'b00, 2'b01});
    tick(); mem_ready = 1'b0;
    #1 chk("str_mw", {state_o, AdrSrc, MemWrite}, {4'd5, 1'b1, 1'b1});
    tick(); chk("str_hold", state_o, 5);
    reset = 1'b1; mem_ready = 1'b1;
    #1 chk("rst_mw_gate", MemWrite, 0);
    tick(); chk("rst_state", state_o, 0);
    chk("rst_strobes", {IRWrite, PCWrite, RegWrite, MemWrite}, 0);
    tick(); reset = 1'b0;
    #1 chk("rel_state", state_o, 0);
    chk("rel_flags", Flags, 4'b0000);

    // ADDS R1
    Op = 2'b00; Funct = 6'b001001; Rd = 4'h1; ALUFlags = 4'b0110;
    strobes("adds_f", 4'b1100);
    tick(); chk("adds_dec", state_o, 1); strobes("adds_dec_s", 4'b0000);
    tick(); chk("adds_exr", {state_o, ALUControl, 2'b00, ALUSrcB},
                {4'd6, 4'b0100, 2'b00, 2'b00});
    chk("adds_exr_rw", RegWrite, 0);
    tick(); chk("adds_wb", {state_o, RegWrite, PCWrite, 2'b00, ResultSrc},
                {4'd8, 1'b1, 1'b0, 2'b00, 2'b00});
    chk("adds_flags", Flags, 4'b0110);
    tick(); chk("adds_end", state_o, 0);

    // CMP then BEQ
    Funct = 6'b010101; ALUFlags = 4'b0100;
    tick(); chk("cmp_dec", state_o, 1);
    tick(); chk("cmp_exr", {state_o, ALUControl}, {4'd6, 4'b1010});
    tick(); chk("cmp_wb", {state_o, RegWrite}, {4'd8, 1'b0});
    chk("cmp_flags", Flags, 4'b0100);
    tick();
    Op = 2'b10; Cond = 4'b0000; Funct = 6'b000000;
    #1 chk("beq_f", state_o, 0);
    chk("beq_imm", {ImmSrc, RegSrc}, {2'b10, 2'b01});
    tick(); chk("beq_dec", state_o, 1);
    tick(); chk("beq_br", {state_o, PCWrite, ALUSrcA, ALUSrcB, ResultSrc},
                {4'd9, 1'b1, 1'b0, 2'b01, 2'b10});
    tick(); chk("beq_end", state_o, 0);

    // BNE with Z=1 fails its condition
    Cond = 4'b0001;
    strobes("bne_f", 4'b1100);
    tick(); chk("bne_dec", state_o, 1); strobes("bne_dec_s", 4'b0000);
    tick(); chk("bne_end", state_o, 0);

    // ANDS: N,Z update; C,V hold from CMP (00)
    Cond = 4'hE; Op = 2'b00; Funct = 6'b100001; ALUFlags = 4'b1011;
    tick(); tick(); chk("ands_exi", {state_o, ALUSrcB}, {4'd7, 2'b01});
    tick(); chk("ands_flags", Flags, 4'b1000);
    chk("ands_wb", RegWrite, 1);
    tick();

    // LDR PC with two wait cycles in MEMREAD
    Op = 2'b01; Funct = 6'b000001; Rd = 4'hF;
    tick(); tick(); chk("ldr_adr", state_o, 2);
    tick(); mem_ready = 1'b0;
    #1 chk("ldr_rd1", {state_o, AdrSrc}, {4'd3, 1'b1});
    tick(); chk("ldr_rd2", state_o, 3);
    tick(); mem_ready = 1'b1;
    #1 chk("ldr_rd3", state_o, 3);
    tick(); chk("ldr_wb", {state_o, RegWrite, PCWrite, 2'b00, ResultSrc},
                {4'd4, 1'b1, 1'b1, 2'b00, 2'b01});
    tick(); chk("ldr_end", state_o, 0);

    // STR on the zero-wait instance with mem_ready tied low
    reset = 1'b1; Funct = 6'b000000; Rd = 4'h2;
    tick(); reset = 1'b0;
    mw_cnt = 0;
    #1 chk("z_f", {state0, IRWrite0}, {4'd0, 1'b1});
    mw_cnt += int'(MemWrite0);
    tick(); chk("z_dec", state0, 1); mw_cnt += int'(MemWrite0);
    tick(); chk("z_adr", state0, 2); mw_cnt += int'(MemWrite0);
    tick(); chk("z_mw", state0, 5); mw_cnt += int'(MemWrite0);
    tick(); chk("z_end", state0, 0); mw_cnt += int'(MemWrite0);
    chk("z_mw_cnt", mw_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
